// File: rtl/compositor_pkg.sv
// Shared types and reset defaults for the layer compositor.
package compositor_pkg;
    localparam int CW_DEF         = 8;
    localparam int MAZE_Y_LIM_DEF = 352;

    typedef struct packed {
        logic [CW_DEF-1:0] r;
        logic [CW_DEF-1:0] g;
        logic [CW_DEF-1:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        PAL_WALL   = 2'd0,
        PAL_FOOD   = 2'd1,
        PAL_BG     = 2'd2,
        PAL_FRIGHT = 2'd3
    } pal_idx_e;

    localparam rgb_t PAL_WALL_DEF   = '{r: 8'hFF, g: 8'h00, b: 8'h00};
    localparam rgb_t PAL_FOOD_DEF   = '{r: 8'hFF, g: 8'hFF, b: 8'h00};
    localparam rgb_t PAL_BG_DEF     = '{r: 8'h3F, g: 8'h00, b: 8'h7F};
    localparam rgb_t PAL_FRIGHT_DEF = '{r: 8'h21, g: 8'h21, b: 8'hFF};
endpackage

// File: rtl/spr_priority_sel.sv
// Lowest-index-wins encoder over the effective sprite hits.
module spr_priority_sel #(
    parameter int N     = 4,
    parameter int SEL_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     eff_hit,
    output logic [SEL_W-1:0] sel,
    output logic             any_hit
);
    always_comb begin
        sel     = '0;
        any_hit = |eff_hit;
        for (int i = N - 1; i >= 0; i--) begin
            if (eff_hit[i]) sel = SEL_W'(i);
        end
    end
endmodule

// File: rtl/layer_compositor.sv
// Two-stage sprite/maze compositor: priority select and keying in stage 1,
// palette lookup and frightened-ghost blink in stage 2.
module layer_compositor
    import compositor_pkg::*;
#(
    parameter int              NUM_SPR      = 4,
    parameter int              CW           = 8,
    parameter int              MAZE_Y_LIM   = MAZE_Y_LIM_DEF,
    parameter logic [3*CW-1:0] TKEY         = '0,
    parameter int              BLINK_FRAMES = 16
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    frame_start,
    input  logic                    pix_valid,
    input  logic [9:0]              DrawX,
    input  logic [9:0]              DrawY,
    input  logic [NUM_SPR-1:0]      spr_hit,
    input  logic [NUM_SPR*3*CW-1:0] spr_rgb,
    input  logic                    is_wall,
    input  logic                    food_present,
    input  logic                    fright,
    input  logic                    fright_end,
    input  logic                    pal_we,
    input  logic [1:0]              pal_addr,
    input  logic [3*CW-1:0]         pal_data,
    output logic                    out_valid,
    output logic [CW-1:0]           VGA_R,
    output logic [CW-1:0]           VGA_G,
    output logic [CW-1:0]           VGA_B
);
    localparam int STAGES = 2;
    localparam int SEL_W  = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;
    localparam int BW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    // Left-align the 8-bit default components into CW bits.
    function automatic logic [3*CW-1:0] scale(input rgb_t c);
        logic [CW+7:0] r, g, b;
        r = {c.r, CW'(0)};
        g = {c.g, CW'(0)};
        b = {c.b, CW'(0)};
        return {r[CW+7 -: CW], g[CW+7 -: CW], b[CW+7 -: CW]};
    endfunction

    logic [NUM_SPR-1:0][3*CW-1:0] spr_arr;
    logic [NUM_SPR-1:0]           eff_hit;
    logic [SEL_W-1:0]             sel;
    logic                         any_hit;

    logic [3:0][3*CW-1:0] pal;
    logic [BW-1:0]        blink_cnt;
    logic                 blink_ph;

    logic [STAGES:1]  vld_pipe;
    logic [SEL_W-1:0] s1_sel;
    logic             s1_any, s1_wall, s1_food, s1_below;
    logic [3*CW-1:0]  s1_rgb;
    logic [3*CW-1:0]  px_rgb;

    logic unused_drawx;
    assign unused_drawx = ^DrawX;

    assign spr_arr = spr_rgb;

    for (genvar i = 0; i < NUM_SPR; i++) begin : g_key
        assign eff_hit[i] = spr_hit[i] && (spr_arr[i] != TKEY);
    end

    spr_priority_sel #(.N(NUM_SPR), .SEL_W(SEL_W)) u_sel (
        .eff_hit (eff_hit),
        .sel     (sel),
        .any_hit (any_hit)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pal[PAL_WALL]   <= scale(PAL_WALL_DEF);
            pal[PAL_FOOD]   <= scale(PAL_FOOD_DEF);
            pal[PAL_BG]     <= scale(PAL_BG_DEF);
            pal[PAL_FRIGHT] <= scale(PAL_FRIGHT_DEF);
        end else if (pal_we) begin
            pal[pal_addr] <= pal_data;
        end
    end

    // Dropping fright_end clears the blink state even if frame_start fires.
    always_ff @(posedge Clk) begin
        if (Reset || !fright_end) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else if (frame_start) begin
            if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt <= '0;
                blink_ph  <= ~blink_ph;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            vld_pipe <= '0;
            s1_sel   <= '0;
            s1_any   <= 1'b0;
            s1_rgb   <= '0;
            s1_wall  <= 1'b0;
            s1_food  <= 1'b0;
            s1_below <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], pix_valid};
            s1_sel   <= sel;
            s1_any   <= any_hit;
            s1_rgb   <= spr_arr[sel];
            s1_wall  <= is_wall;
            s1_food  <= food_present;
            s1_below <= (DrawY >= 10'(MAZE_Y_LIM));
        end
    end

    always_comb begin
        px_rgb = pal[PAL_BG];
        if (s1_any) begin
            if (s1_sel != '0 && fright && !(fright_end && blink_ph))
                px_rgb = pal[PAL_FRIGHT];
            else
                px_rgb = s1_rgb;
        end else if (s1_wall && !s1_below) begin
            px_rgb = pal[PAL_WALL];
        end else if (s1_food && !s1_below) begin
            px_rgb = pal[PAL_FOOD];
        end
    end

    // Colour registers only move on valid pixels so bubbles hold the last value.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            {VGA_R, VGA_G, VGA_B} <= '0;
        end else if (vld_pipe[STAGES-1]) begin
            {VGA_R, VGA_G, VGA_B} <= px_rgb;
        end
    end

    assign out_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_layer_compositor.sv
// Directed bench for layer_compositor with hand-computed colours.
module tb_layer_compositor;
    logic        Clk = 1'b0;
    logic        Reset, frame_start, pix_valid;
    logic [9:0]  DrawX, DrawY;
    logic [3:0]  spr_hit;
    logic [95:0] spr_rgb;
    logic        is_wall, food_present, fright, fright_end, pal_we;
    logic [1:0]  pal_addr;
    logic [23:0] pal_data;
    logic        out_valid;
    logic [7:0]  VGA_R, VGA_G, VGA_B;

    int n_run = 0;
    int n_fail = 0;

    always #5 Clk = ~Clk;

    layer_compositor dut (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .pix_valid(pix_valid),
        .DrawX(DrawX), .DrawY(DrawY), .spr_hit(spr_hit), .spr_rgb(spr_rgb),
        .is_wall(is_wall), .food_present(food_present), .fright(fright),
        .fright_end(fright_end), .pal_we(pal_we), .pal_addr(pal_addr),
        .pal_data(pal_data), .out_valid(out_valid),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
    );

    task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %06h expected %06h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Pixel enters at the next edge; returns after the second edge, when it should be out.
    task automatic px(input logic [3:0] hit, input logic [95:0] rgb, input logic wall,
                      input logic food, input logic [9:0] y);
        spr_hit = hit; spr_rgb = rgb; is_wall = wall; food_present = food; DrawY = y;
        DrawX = 10'd5; pix_valid = 1'b1;
        tick();
        pix_valid = 1'b0; spr_hit = '0; is_wall = 1'b0; food_present = 1'b0;
        pal_we = 1'b0;
        chk("lat_early", {23'd0, out_valid}, 24'd0);
        tick();
        chk("out_valid", {23'd0, out_valid}, 24'd1);
    endtask

    task automatic pulse_frames(input int n);
        for (int k = 0; k < n; k++) begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            tick();
        end
    endtask

    logic [95:0] rgbs;

    initial begin
        Reset = 1'b1; frame_start = 0; pix_valid = 0; DrawX = 0; DrawY = 0;
        spr_hit = 0; spr_rgb = 0; is_wall = 0; food_present = 0; fright = 0;
        fright_end = 0; pal_we = 0; pal_addr = 0; pal_data = 0;
        tick(); tick();
        Reset = 1'b0;
        tick();

        // 1: reset state and background pixel
        chk("rst_valid", {23'd0, out_valid}, 24'd0);
        chk("rst_rgb", {VGA_R, VGA_G, VGA_B}, 24'h000000);
        px(4'b0000, '0, 0, 0, 10'd10);
        chk("bg", {VGA_R, VGA_G, VGA_B}, 24'h3F007F);
        tick();
        chk("bubble_valid", {23'd0, out_valid}, 24'd0);
        chk("bubble_hold", {VGA_R, VGA_G, VGA_B}, 24'h3F007F);

        // 2: priority and transparency keying
        rgbs = {24'h0000FF, 24'h00FF00, 24'hFF0000, 24'h123456};
        px(4'b0110, rgbs, 0, 0, 10'd10);
        chk("prio_spr1", {VGA_R, VGA_G, VGA_B}, 24'hFF0000);
        rgbs = {24'h0000FF, 24'h00FF00, 24'h000000, 24'h123456};
        px(4'b0110, rgbs, 0, 0, 10'd10);
        chk("key_spr2", {VGA_R, VGA_G, VGA_B}, 24'h00FF00);
        rgbs = {24'h0000FF, 24'h000000, 24'h000000, 24'h123456};
        px(4'b0110, rgbs, 1, 0, 10'd10);
        chk("all_keyed_wall", {VGA_R, VGA_G, VGA_B}, 24'hFF0000);

        // 3: frightened mode
        fright = 1'b1;
        rgbs = {24'h0000FF, 24'h00FF00, 24'hFF0000, 24'hABCDEF};
        px(4'b0011, rgbs, 0, 0, 10'd10);
        chk("fright_pac", {VGA_R, VGA_G, VGA_B}, 24'hABCDEF);
        px(4'b0010, rgbs, 0, 0, 10'd10);
        chk("fright_ghost", {VGA_R, VGA_G, VGA_B}, 24'h2121FF);

        // 4: blink
        fright_end = 1'b1;
        pulse_frames(15);
        px(4'b0010, rgbs, 0, 0, 10'd10);
        chk("blink_15", {VGA_R, VGA_G, VGA_B}, 24'h2121FF);
        pulse_frames(1);
        px(4'b0010, rgbs, 0, 0, 10'd10);
        chk("blink_16", {VGA_R, VGA_G, VGA_B}, 24'hFF0000);
        pulse_frames(5);
        fright_end = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        fright_end = 1'b1;
        px(4'b0010, rgbs, 0, 0, 10'd10);
        chk("blink_clr_ph", {VGA_R, VGA_G, VGA_B}, 24'h2121FF);
        pulse_frames(15);
        px(4'b0010, rgbs, 0, 0, 10'd10);
        chk("blink_clr_cnt", {VGA_R, VGA_G, VGA_B}, 24'h2121FF);
        fright_end = 1'b0; fright = 1'b0;

        // 5: palette writes and maze boundary
        pal_we = 1'b1; pal_addr = 2'd0; pal_data = 24'h00FF00;
        tick();
        pal_we = 1'b0;
        px(4'b0000, '0, 1, 0, 10'd100);
        chk("pal_wall", {VGA_R, VGA_G, VGA_B}, 24'h00FF00);
        px(4'b0000, '0, 1, 0, 10'd351);
        chk("wall_y351", {VGA_R, VGA_G, VGA_B}, 24'h00FF00);
        px(4'b0000, '0, 1, 0, 10'd352);
        chk("wall_y352", {VGA_R, VGA_G, VGA_B}, 24'h3F007F);
        px(4'b0000, '0, 0, 1, 10'd200);
        chk("food", {VGA_R, VGA_G, VGA_B}, 24'hFFFF00);
        px(4'b0000, '0, 0, 1, 10'd400);
        chk("food_below", {VGA_R, VGA_G, VGA_B}, 24'h3F007F);
        pal_we = 1'b1; pal_addr = 2'd2; pal_data = 24'h123456;
        px(4'b0000, '0, 0, 0, 10'd10);
        chk("pal_wbr", {VGA_R, VGA_G, VGA_B}, 24'h123456);

        // 6: reset with pixels in flight
        spr_hit = 0; DrawY = 10'd100; is_wall = 1'b1; pix_valid = 1'b1;
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0; pix_valid = 1'b0; is_wall = 1'b0;
        chk("rst_fl_v0", {23'd0, out_valid}, 24'd0);
        chk("rst_fl_rgb", {VGA_R, VGA_G, VGA_B}, 24'h000000);
        tick();
        chk("rst_fl_v1", {23'd0, out_valid}, 24'd0);
        tick();
        chk("rst_fl_v2", {23'd0, out_valid}, 24'd0);
        px(4'b0000, '0, 1, 0, 10'd100);
        chk("rst_pal_wall", {VGA_R, VGA_G, VGA_B}, 24'hFF0000);
        px(4'b0000, '0, 0, 0, 10'd10);
        chk("rst_pal_bg", {VGA_R, VGA_G, VGA_B}, 24'h3F007F);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
